balance_cntrl_pipe: RTL and testbench



---
 rtl/balance_pkg.sv | 20 ++
 rtl/balance_cntrl_pipe_if.sv | 26 ++
 rtl/bal_pid_core.sv | 54 +++++
 rtl/balance_cntrl_pipe.sv | 114 +++++++++++
 tb/tb_balance_cntrl_pipe.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/balance_pkg.sv
// Shared constants and saturation helper for the pipelined balance controller.
package balance_pkg;
  localparam int P_COEF    = 5;
  localparam int PTCH_MIN  = -512;
  localparam int PTCH_MAX  = 511;
  localparam int RT_MIN    = -2048;
  localparam int RT_MAX    = 2047;
  localparam int STEER_LO  = 'h200;
  localparam int STEER_HI  = 'hE00;
  localparam int STEER_MID = 'h7FF;
  localparam int PID_MIN   = -4096;
  localparam int PID_MAX   = 4095;
  localparam int INTEG_MAX = 131071;

  function automatic int sat(input int val, input int lo, input int hi);
    if (val < lo)      return lo;
    else if (val > hi) return hi;
    else               return val;
  endfunction
endpackage

// File: rtl/balance_cntrl_pipe_if.sv
// Sample-side and drive-side signals of the balance controller.
interface balance_cntrl_pipe_if #(
  parameter int W_IN  = 16,
  parameter int W_OUT = 12
);
  logic signed [W_IN-1:0]  ptch;
  logic signed [W_IN-1:0]  ptch_rt;
  logic                    vld;
  logic                    pwr_up;
  logic                    rider_off;
  logic [11:0]             steer_pot;
  logic                    en_steer;
  logic signed [W_OUT-1:0] lft_spd;
  logic signed [W_OUT-1:0] rght_spd;
  logic                    out_vld;
  logic                    too_fast;

  modport master (
    output ptch, ptch_rt, vld, pwr_up, rider_off, steer_pot, en_steer,
    input  lft_spd, rght_spd, out_vld, too_fast
  );
  modport slave (
    input  ptch, ptch_rt, vld, pwr_up, rider_off, steer_pot, en_steer,
    output lft_spd, rght_spd, out_vld, too_fast
  );
endinterface

// File: rtl/bal_pid_core.sv
// Input clamping, integrator and saturated PID sum; pid is valid while pid_vld is high.
module bal_pid_core
  import balance_pkg::*;
#(
  parameter int W_IN     = 16,
  parameter int FAST_SIM = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [W_IN-1:0] ptch,
  input  logic signed [W_IN-1:0] ptch_rt,
  input  logic                   vld,
  input  logic                   rider_off,
  output logic signed [12:0]     pid,
  output logic                   pid_vld
);
  localparam int I_SHIFT = (FAST_SIM != 0) ? 1 : 6;

  logic signed [9:0]  ptch_c, ptch_s_p0;
  logic signed [11:0] rt_c, rt_s_p0;
  logic               vld_p0;
  logic signed [17:0] integ, integ_nxt;
  int                 pid_sum;

  always_comb begin
    ptch_c    = 10'(sat(int'(ptch), PTCH_MIN, PTCH_MAX));
    rt_c      = 12'(sat(int'(ptch_rt), RT_MIN, RT_MAX));
    integ_nxt = 18'(sat(int'(integ) + int'(ptch_s_p0), -INTEG_MAX, INTEG_MAX));
    // I term uses the integrator value before this sample's accumulation
    pid_sum   = P_COEF * int'(ptch_s_p0) + (int'(integ) >>> I_SHIFT)
                - (int'(rt_s_p0) >>> 6);
    pid       = 13'(sat(pid_sum, PID_MIN, PID_MAX));
  end

  // ---- stage 0: clamped input registers ----
  always_ff @(posedge clk) begin
    if (vld) begin
      ptch_s_p0 <= ptch_c;
      rt_s_p0   <= rt_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= vld;
  end

  always_ff @(posedge clk) begin
    if (rst || rider_off) integ <= '0;
    else if (vld_p0)      integ <= integ_nxt;
  end

  assign pid_vld = vld_p0;
endmodule

// File: rtl/balance_cntrl_pipe.sv
// Pipelined balance controller top: PID core, soft-start scaling, steering mixer, overspeed filter.
module balance_cntrl_pipe
  import balance_pkg::*;
#(
  parameter int W_IN     = 16,
  parameter int W_OUT    = 12,
  parameter int PIPE     = 1,
  parameter int FAST_SIM = 1,
  parameter int SS_W     = 8,
  parameter int FAST_THR = 1536,
  parameter int FAST_CNT = 4
) (
  input logic                  clk,
  input logic                  rst,
  balance_cntrl_pipe_if.slave  bus
);
  localparam int SS_STEP = (FAST_SIM != 0) ? 16 : 1;
  localparam int SS_MAX  = (1 << SS_W) - 1;
  localparam int OUT_MAX = (1 << (W_OUT - 1)) - 1;
  localparam int OUT_MIN = -(1 << (W_OUT - 1));
  localparam int CNT_W   = $clog2(FAST_CNT + 1);

  logic signed [12:0]      pid, pid_mix;
  logic                    pid_vld, vld_mix;
  logic [SS_W-1:0]         ss_tmr, ss_nxt;
  int                      pid_ss, pot_c, steer;
  logic signed [W_OUT-1:0] lft_c, rght_c, lft_p2, rght_p2;
  logic                    fast, vld_p2, too_fast_p2;
  logic [CNT_W-1:0]        fast_cnt;

  bal_pid_core #(.W_IN(W_IN), .FAST_SIM(FAST_SIM)) u_core (
    .clk       (clk),
    .rst       (rst),
    .ptch      (bus.ptch),
    .ptch_rt   (bus.ptch_rt),
    .vld       (bus.vld),
    .rider_off (bus.rider_off),
    .pid       (pid),
    .pid_vld   (pid_vld)
  );

  assign ss_nxt = SS_W'(sat(int'(ss_tmr) + SS_STEP, 0, SS_MAX));

  always_ff @(posedge clk) begin
    if (rst || !bus.pwr_up) ss_tmr <= '0;
    else if (pid_vld)       ss_tmr <= ss_nxt;
  end

  // ---- stage 1..PIPE: optional delay between PID sum and mixer ----
  if (PIPE == 0) begin : g_nopipe
    assign pid_mix = pid;
    assign vld_mix = pid_vld;
  end else begin : g_pipe
    logic signed [12:0] pid_p1 [PIPE];
    logic               vld_p1 [PIPE];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < PIPE; i++) vld_p1[i] <= 1'b0;
      end else begin
        vld_p1[0] <= pid_vld;
        for (int i = 1; i < PIPE; i++) vld_p1[i] <= vld_p1[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (pid_vld) pid_p1[0] <= pid;
      for (int i = 1; i < PIPE; i++)
        if (vld_p1[i-1]) pid_p1[i] <= pid_p1[i-1];
    end

    assign pid_mix = pid_p1[PIPE-1];
    assign vld_mix = vld_p1[PIPE-1];
  end

  always_comb begin
    pid_ss = (int'(pid_mix) * int'(ss_tmr)) >>> SS_W;
    pot_c  = sat(int'(bus.steer_pot), STEER_LO, STEER_HI);
    steer  = bus.en_steer ? (((pot_c - STEER_MID) * 3) >>> 4) : 0;
    lft_c  = bus.pwr_up ? W_OUT'(sat(pid_ss + steer, OUT_MIN, OUT_MAX)) : '0;
    rght_c = bus.pwr_up ? W_OUT'(sat(pid_ss - steer, OUT_MIN, OUT_MAX)) : '0;
    fast   = (int'(lft_c) > FAST_THR)  || (int'(lft_c) < -FAST_THR) ||
             (int'(rght_c) > FAST_THR) || (int'(rght_c) < -FAST_THR);
  end

  // ---- stage 2+PIPE: registered outputs and overspeed persistence ----
  always_ff @(posedge clk) begin
    if (rst) begin
      lft_p2      <= '0;
      rght_p2     <= '0;
      vld_p2      <= 1'b0;
      too_fast_p2 <= 1'b0;
      fast_cnt    <= '0;
    end else begin
      vld_p2 <= vld_mix;
      if (vld_mix) begin
        lft_p2  <= lft_c;
        rght_p2 <= rght_c;
        if (fast) begin
          if (int'(fast_cnt) < FAST_CNT) fast_cnt <= fast_cnt + 1'b1;
          too_fast_p2 <= (int'(fast_cnt) + 1 >= FAST_CNT);
        end else begin
          fast_cnt    <= '0;
          too_fast_p2 <= 1'b0;
        end
      end
    end
  end

  assign bus.lft_spd  = lft_p2;
  assign bus.rght_spd = rght_p2;
  assign bus.out_vld  = vld_p2;
  assign bus.too_fast = too_fast_p2;
endmodule

// File: tb/tb_balance_cntrl_pipe.sv
// Directed bench for balance_cntrl_pipe: main instance PIPE=1, plus PIPE=0/2 for throughput.
module tb_balance_cntrl_pipe;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  int   last_lat;

  always #5 clk = ~clk;

  balance_cntrl_pipe_if #(.W_IN(16), .W_OUT(12)) bus  ();
  balance_cntrl_pipe_if #(.W_IN(16), .W_OUT(12)) bus0 ();
  balance_cntrl_pipe_if #(.W_IN(16), .W_OUT(12)) bus2 ();

  assign bus0.ptch = bus.ptch;  assign bus0.ptch_rt = bus.ptch_rt;  assign bus0.vld = bus.vld;
  assign bus0.pwr_up = bus.pwr_up;  assign bus0.rider_off = bus.rider_off;
  assign bus0.steer_pot = bus.steer_pot;  assign bus0.en_steer = bus.en_steer;
  assign bus2.ptch = bus.ptch;  assign bus2.ptch_rt = bus.ptch_rt;  assign bus2.vld = bus.vld;
  assign bus2.pwr_up = bus.pwr_up;  assign bus2.rider_off = bus.rider_off;
  assign bus2.steer_pot = bus.steer_pot;  assign bus2.en_steer = bus.en_steer;

  balance_cntrl_pipe #(.PIPE(1)) dut  (.clk(clk), .rst(rst), .bus(bus));
  balance_cntrl_pipe #(.PIPE(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  balance_cntrl_pipe #(.PIPE(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic check_val(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one sample, then wait (bounded) for its out_vld on the main instance.
  task automatic send(input int p, input int r);
    int n;
    bus.ptch    = 16'(p);
    bus.ptch_rt = 16'(r);
    bus.vld     = 1'b1;
    step();
    bus.vld = 1'b0;
    n = 1;
    while (!bus.out_vld && n < 10) begin
      step();
      n++;
    end
    last_lat = n;
    if (!bus.out_vld) check_val("out_vld_timeout", 0, 1);
  endtask

  task automatic sample(input string tag, input int p, input int r,
                        input int el, input int er, input int etf);
    send(p, r);
    check_val({tag, "_lft"},  int'(bus.lft_spd),  el);
    check_val({tag, "_rght"}, int'(bus.rght_spd), er);
    check_val({tag, "_tf"},   int'(bus.too_fast), etf);
  endtask

  initial begin
    int nv, f0, f1, f2, c0, c1, c2, l0, l1, l2;
    rst = 1'b1;
    bus.ptch = '0; bus.ptch_rt = '0; bus.vld = 1'b0; bus.pwr_up = 1'b0;
    bus.rider_off = 1'b0; bus.steer_pot = 12'h7FF; bus.en_steer = 1'b0;
    step(); step();
    check_val("rst_out_vld",  int'(bus.out_vld),  0);
    check_val("rst_lft",      int'(bus.lft_spd),  0);
    check_val("rst_rght",     int'(bus.rght_spd), 0);
    check_val("rst_too_fast", int'(bus.too_fast), 0);
    rst = 1'b0;

    // Warm-up: soft-start timer reaches 255, integrator held at 0
    bus.pwr_up = 1'b1; bus.rider_off = 1'b1; bus.ptch = '0;
    for (int i = 0; i < 20; i++) begin
      bus.vld = 1'b1;
      step();
    end
    bus.vld = 1'b0;
    repeat (5) step();

    // Basic P path: 500*255>>>8 = 498
    bus.rider_off = 1'b0;
    sample("p100", 100, 0, 498, 498, 0);
    check_val("latency", last_lat, 3);
    step();
    check_val("hold_out_vld", int'(bus.out_vld), 0);
    check_val("hold_lft",     int'(bus.lft_spd), 498);

    // Steering and D term (rider_off keeps integrator at 0)
    bus.rider_off = 1'b1; bus.en_steer = 1'b1;
    bus.steer_pot = 12'hFFF; sample("steer_hi", 0, 0, 288, -288, 0);
    bus.steer_pot = 12'h000; sample("steer_lo", 0, 0, -288, 288, 0);
    bus.en_steer = 1'b0;
    sample("d_neg_clamp", 0, -5000, 31, 31, 0);
    sample("d_pos",       0, 100,   -1, -1, 0);

    // Output saturation and overspeed persistence
    sample("sat1", 2000, 0, 2047, 2047, 0);
    sample("sat2", 2000, 0, 2047, 2047, 0);
    sample("sat3", 2000, 0, 2047, 2047, 0);
    sample("sat4", 2000, 0, 2047, 2047, 1);
    sample("sat_clr", 0, 0, 0, 0, 0);

    // Integrator: I uses the pre-update value; clear beats a simultaneous sample
    bus.rider_off = 1'b0;
    sample("int1", 10, 0, 49, 49, 0);
    sample("int2", 10, 0, 54, 54, 0);
    sample("int3", 10, 0, 59, 59, 0);
    bus.rider_off = 1'b1;
    sample("int_clr", 10, 0, 49, 49, 0);
    bus.rider_off = 1'b0;
    sample("int_after_clr", 0, 0, 0, 0, 0);

    // Power drop zeroes outputs and restarts soft-start (first step 16 -> 500*16>>>8 = 31)
    bus.rider_off = 1'b1; bus.pwr_up = 1'b0;
    sample("pwr_off", 100, 0, 0, 0, 0);
    bus.pwr_up = 1'b1;
    sample("pwr_restart", 100, 0, 31, 31, 0);

    // Reset with samples in flight drops them
    bus.ptch = 16'd100; bus.vld = 1'b1;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0; bus.vld = 1'b0;
    check_val("midrst_out_vld", int'(bus.out_vld), 0);
    check_val("midrst_lft",     int'(bus.lft_spd), 0);
    check_val("midrst_rght",    int'(bus.rght_spd), 0);
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.out_vld) nv++;
    end
    check_val("midrst_no_vld", nv, 0);

    // Throughput: 10 back-to-back samples on PIPE = 0, 1, 2
    f0 = -1; f1 = -1; f2 = -1; c0 = 0; c1 = 0; c2 = 0; l0 = -1; l1 = -1; l2 = -1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      bus.vld = (cyc < 10);
      step();
      if (bus0.out_vld) begin if (f0 < 0) f0 = cyc; c0++; l0 = cyc; end
      if (bus.out_vld)  begin if (f1 < 0) f1 = cyc; c1++; l1 = cyc; end
      if (bus2.out_vld) begin if (f2 < 0) f2 = cyc; c2++; l2 = cyc; end
    end
    check_val("tp0_first", f0, 1);  check_val("tp0_count", c0, 10);  check_val("tp0_last", l0, 10);
    check_val("tp1_first", f1, 2);  check_val("tp1_count", c1, 10);  check_val("tp1_last", l1, 11);
    check_val("tp2_first", f2, 3);  check_val("tp2_count", c2, 10);  check_val("tp2_last", l2, 12);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
